// File: rtl/conversor_grey_pkg.sv
// Shared types and helpers for the Gray-to-binary decoder.
// popcount is only referenced when GREY_STEP_CHECK_EN is defined.
package conversor_grey_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int MAX_WIDTH     = 16;

  // Callers zero-extend narrower codes; leading zeros decode to leading zeros,
  // so one MAX_WIDTH loop serves every legal WIDTH.
  function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] g);
    logic [MAX_WIDTH-1:0] b;
    b[MAX_WIDTH-1] = g[MAX_WIDTH-1];
    for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [4:0] popcount(input logic [MAX_WIDTH-1:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      n = n + {4'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/grey_step_checker.sv
// Flags accepted Gray codes that are not a single-bit step from the previous
// accepted code, and keeps a saturating count of such errors.
module grey_step_checker
  import conversor_grey_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 acc,
  input  logic [WIDTH-1:0]     gray,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_count
);

  logic [WIDTH-1:0]     prev_p1;
  logic                 first_p1;
  logic [ERR_CNT_W-1:0] cnt_p1;
  logic [MAX_WIDTH-1:0] diff;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] c);
    return (&c) ? c : c + ERR_CNT_W'(1);
  endfunction

  // An identical repeat (zero bits changed) is an error as well.
  assign diff      = MAX_WIDTH'(gray ^ prev_p1);
  assign err       = !first_p1 && (popcount(diff) != 5'd1);
  assign err_count = cnt_p1;

  // p1: previous code, first-code flag, error counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_p1  <= '0;
      first_p1 <= 1'b1;
      cnt_p1   <= '0;
    end else if (acc) begin
      prev_p1  <= gray;
      first_p1 <= 1'b0;
      if (err) cnt_p1 <= sat_inc(cnt_p1);
    end
  end

endmodule

// File: rtl/conversor_grey_binario_seq.sv
// Registered Gray-to-binary decoder with a one-entry valid/ready output stage.
// Define GREY_STEP_CHECK_EN to add the single-bit-step checker.
module conversor_grey_binario_seq
  import conversor_grey_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_gray,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_binario,
  output logic                 step_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  logic                 acc_p0;
  logic [MAX_WIDTH-1:0] bin_full_p0;
  logic                 vld_p1;
  logic [WIDTH-1:0]     bin_p1;

  assign in_ready    = !vld_p1 || out_ready;
  assign acc_p0      = in_valid && in_ready;
  assign bin_full_p0 = gray2bin(MAX_WIDTH'(in_gray));

  // p0 -> p1: output register loads on accept, empties on consume without refill
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      bin_p1 <= '0;
    end else if (acc_p0) begin
      vld_p1 <= 1'b1;
      bin_p1 <= bin_full_p0[WIDTH-1:0];
    end else if (out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign out_valid   = vld_p1;
  assign out_binario = bin_p1;

`ifdef GREY_STEP_CHECK_EN
  logic serr_p0;
  logic serr_p1;

  grey_step_checker #(
    .WIDTH     (WIDTH),
    .ERR_CNT_W (ERR_CNT_W)
  ) u_step_checker (
    .clk       (clk),
    .rst_n     (rst_n),
    .acc       (acc_p0),
    .gray      (in_gray),
    .err       (serr_p0),
    .err_count (err_count)
  );

  // p1: step flag travels with the decoded value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      serr_p1 <= 1'b0;
    end else if (acc_p0) begin
      serr_p1 <= serr_p0;
    end
  end

  assign step_err = serr_p1;
`else
  assign step_err  = 1'b0;
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_conversor_grey_binario_seq.sv
// Scoreboard bench for conversor_grey_binario_seq: directed scenarios plus
// randomized traffic checked against a search-based reference decoder.
module tb_conversor_grey_binario_seq;

  localparam int W  = 4;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_gray;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_binario;
  logic          step_err;
  logic [CW-1:0] err_count;

  always #5 clk = ~clk;

  conversor_grey_binario_seq #(.WIDTH(W), .ERR_CNT_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_gray     (in_gray),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_binario (out_binario),
    .step_err    (step_err),
    .err_count   (err_count)
  );

  typedef struct {
    logic [W-1:0]  bin;
    logic          serr;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t         sbq[$];
  int           checks = 0;
  int           passes = 0;
  logic [W-1:0] m_prev = '0;
  bit           m_first = 1'b1;
  int           m_cnt = 0;
  bit           rand_mode = 1'b0;
  bit           nobubble = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [W-1:0] to_gray(input int b);
    return W'(b ^ (b >> 1));
  endfunction

  // Reference decode: find the binary value whose Gray code matches.
  function automatic logic [W-1:0] ref_decode(input logic [W-1:0] g);
    for (int b = 0; b < (1 << W); b++)
      if (to_gray(b) == g) return W'(b);
    return '0;
  endfunction

  task automatic model_accept(input logic [W-1:0] g);
    exp_t e;
    e.bin = ref_decode(g);
`ifdef GREY_STEP_CHECK_EN
    e.serr = !m_first && ($countones(g ^ m_prev) != 1);
    if (e.serr && m_cnt < (1 << CW) - 1) m_cnt++;
`else
    e.serr = 1'b0;
`endif
    e.cnt   = CW'(m_cnt);
    m_prev  = g;
    m_first = 1'b0;
    sbq.push_back(e);
  endtask

  task automatic model_reset();
    sbq.delete();
    m_prev  = '0;
    m_first = 1'b1;
    m_cnt   = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    if (rand_mode) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [W-1:0] g);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_gray  = g;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (nobubble) chk("no_bubble", 32'(out_valid), 32'd1);
      if (in_ready) begin
        model_accept(g);
        done = 1'b1;
      end
      next_cycle();
    end
    if (!done) chk("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) next_cycle();
  endtask

  task automatic drain();
    bit empty;
    empty     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 50 && !empty; n++) begin
      next_cycle();
      empty = (sbq.size() == 0) && !out_valid;
    end
    chk("drain", 32'(empty), 32'd1);
  endtask

  // Monitor: each value is checked in the cycle the consumer takes it.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          chk("unexpected_output", 32'(out_binario), 32'hffff_ffff);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("out_binario", 32'(out_binario), 32'(e.bin));
          chk("step_err", 32'(step_err), 32'(e.serr));
          chk("err_count", 32'(err_count), 32'(e.cnt));
        end
      end
    end
  end

  initial begin
    logic [W-1:0] g;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_gray   = '0;
    out_ready = 1'b0;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_binario", 32'(out_binario), 32'd0);
    chk("rst_step_err", 32'(step_err), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed decodes, one-cycle latency
    out_ready = 1'b1;
    send(4'b0110);
    chk("lat_0110", 32'({out_valid, out_binario}), 32'({1'b1, 4'b0100}));
    send(4'b1000);
    chk("lat_1000", 32'({out_valid, out_binario}), 32'({1'b1, 4'b1111}));
    send(4'b0011);
    chk("lat_0011", 32'({out_valid, out_binario}), 32'({1'b1, 4'b0010}));
    drain();

    // Exhaustive back-to-back
    for (int i = 0; i < (1 << W); i++) begin
      nobubble = (i > 0);
      send(to_gray(i));
    end
    nobubble = 1'b0;
    @(negedge clk);
    chk("no_bubble_last", 32'(out_valid), 32'd1);
    drain();

    // Backpressure
    send(4'b0101);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_gray   = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_hold", 32'({out_valid, out_binario}), 32'({1'b1, 4'b0110}));
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(4'b1111);
    chk("after_stall", 32'(out_binario), 32'(4'b1010));
    drain();

    // Reset while stalled
    out_ready = 1'b0;
    send(4'b0111);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_binario", 32'(out_binario), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_err_count", 32'(err_count), 32'd0);

    // Step-check sequence, then repeats to saturate the counter
    out_ready = 1'b1;
    send(4'b0000);
    send(4'b0001);
    send(4'b0011);
    send(4'b0000);
    send(4'b0000);
    repeat (3) send(4'b0000);
    drain();
`ifdef GREY_STEP_CHECK_EN
    chk("err_count_sat", 32'(err_count), 32'd3);
`else
    chk("err_count_tied", 32'(err_count), 32'd0);
`endif

    // Randomized traffic: mostly single-bit steps, some arbitrary jumps
    rand_mode = 1'b1;
    g = '0;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
      if ($urandom_range(0, 1) == 0) g = g ^ W'(1 << $urandom_range(0, W - 1));
      else g = W'($urandom);
      send(g);
    end
    rand_mode = 1'b0;
    drain();
    chk("err_count_final", 32'(err_count), 32'(m_cnt));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
